// File: rtl/rbm_pkg.sv
// Shared types and arithmetic helpers for the parallel RBM layer.
package rbm_pkg;

   // Layer controller states
   typedef enum logic [2:0] {
      IDLE,
      BIAS,
      ACCUM,
      SAMPLE,
      DONE
   } state_t;

   // Working width for the width-generic arithmetic helpers below
   localparam int CALC_W = 64;

   // Bits needed to index 'value' entries; never less than one bit
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits++;
         rem = rem >> 1;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

   // Sign-extend the low 'width' bits of a weight/bias word to CALC_W bits
   function automatic logic signed [CALC_W-1:0] sext_w2acc(input logic [CALC_W-1:0] value,
                                                           input int width);
      logic [CALC_W-1:0] shifted;
      shifted = value << (CALC_W - width);
      return $signed(shifted) >>> (CALC_W - width);
   endfunction

   // Signed add clamped to the range of a 'width'-bit two's complement number
   function automatic logic signed [CALC_W-1:0] sat_add(input logic signed [CALC_W-1:0] a,
                                                        input logic signed [CALC_W-1:0] b,
                                                        input int width);
      logic signed [CALC_W-1:0] sum;
      logic signed [CALC_W-1:0] max_val;
      logic signed [CALC_W-1:0] min_val;
      sum     = a + b;
      max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_val = -max_val - 64'sd1;
      if (sum > max_val) begin
         return max_val;
      end
      if (sum < min_val) begin
         return min_val;
      end
      return sum;
   endfunction

endpackage

// File: rtl/rbm_neuron_lane.sv
// One neuron lane: saturating accumulator, sigmoid approximation and sampler.
module rbm_neuron_lane
   import rbm_pkg::*;
#(
   parameter int BITLENGTH         = 16,
   parameter int W_BITLENGTH       = 12,
   parameter int SIGMOID_BITLENGTH = 8,
   parameter int SAMPLE_MODE       = 0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         load_bias,
   input  logic                         accum_en,
   input  logic [W_BITLENGTH-1:0]       value,
   input  logic [SIGMOID_BITLENGTH-1:0] rand_val,
   output logic                         sample_bit
);

   localparam logic signed [CALC_W-1:0] SIG_MID = 64'sd1 <<< (SIGMOID_BITLENGTH - 1);
   localparam logic signed [CALC_W-1:0] SIG_MAX = (64'sd1 <<< SIGMOID_BITLENGTH) - 64'sd1;

   logic signed [BITLENGTH-1:0]   acc_reg;
   logic signed [BITLENGTH-1:0]   acc_next;
   logic signed [CALC_W-1:0]      acc_wide;
   logic signed [CALC_W-1:0]      sig_wide;
   logic [SIGMOID_BITLENGTH-1:0]  sig;

   // Next accumulator value: bias load overrides, otherwise saturating add of the weight
   always_comb begin
      acc_wide = CALC_W'(acc_reg);
      acc_next = acc_reg;
      if (load_bias) begin
         acc_next = BITLENGTH'(sext_w2acc(CALC_W'(value), W_BITLENGTH));
      end else if (accum_en) begin
         acc_next = BITLENGTH'(sat_add(acc_wide, sext_w2acc(CALC_W'(value), W_BITLENGTH), BITLENGTH));
      end
   end

   // Accumulator register
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_next;
      end
   end

   // Piecewise-linear sigmoid: midpoint plus acc/4, clamped to the output range
   always_comb begin
      sig_wide = (acc_wide >>> 2) + SIG_MID;
      if (sig_wide < 0) begin
         sig = '0;
      end else if (sig_wide > SIG_MAX) begin
         sig = '1;
      end else begin
         sig = SIGMOID_BITLENGTH'(sig_wide);
      end
   end

   assign sample_bit = (SAMPLE_MODE != 0) ? !acc_reg[BITLENGTH-1] : (sig > rand_val);

endmodule

// File: rtl/rbm_layer_par.sv
// RBM layer computing OUTPUT_DIM binary neurons, LANES at a time, with a
// writable weight/bias store and valid/ready handshakes on both sides.
module rbm_layer_par
   import rbm_pkg::*;
#(
   parameter int BITLENGTH         = 16,
   parameter int W_BITLENGTH       = 12,
   parameter int SIGMOID_BITLENGTH = 8,
   parameter int INPUT_DIM         = 15,
   parameter int OUTPUT_DIM        = 5,
   parameter int LANES             = 2,
   parameter int SAMPLE_MODE       = 0,
   localparam int ROW_W            = clog2(INPUT_DIM + 1),
   localparam int COL_W            = clog2(OUTPUT_DIM)
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 w_wr_en,
   input  logic [ROW_W-1:0]                     w_wr_row,
   input  logic [COL_W-1:0]                     w_wr_col,
   input  logic [W_BITLENGTH-1:0]               w_wr_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [INPUT_DIM-1:0]                 InputData,
   input  logic [LANES*SIGMOID_BITLENGTH-1:0]   rand_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OUTPUT_DIM-1:0]                OutputData
);

   localparam int GROUPS = (OUTPUT_DIM + LANES - 1) / LANES;
   localparam int GRP_W  = clog2(GROUPS);
   localparam int IDX_W  = clog2(INPUT_DIM);

   state_t                  state_reg;
   logic [GRP_W-1:0]        g_reg;
   logic [IDX_W-1:0]        i_reg;
   logic [INPUT_DIM-1:0]    in_latched_reg;
   logic                    in_ready_reg;
   logic                    out_valid_reg;
   logic [OUTPUT_DIM-1:0]   out_data_reg;

   logic                    wr_ok;
   logic [ROW_W-1:0]        rd_row;
   logic [W_BITLENGTH-1:0]  rd_word [OUTPUT_DIM];
   logic                    load_bias;
   logic                    accum_en;
   logic [LANES-1:0]        lane_bit;

   // Writes only land while idle with no vector being offered, and only in range
   assign wr_ok = w_wr_en && (state_reg == IDLE) && !in_valid &&
                  (w_wr_row <= ROW_W'(INPUT_DIM)) &&
                  ({1'b0, w_wr_col} < (COL_W + 1)'(OUTPUT_DIM));

   // Read address runs one cycle ahead: the row the next state will consume
   always_comb begin
      rd_row = ROW_W'(INPUT_DIM);
      case (state_reg)
         BIAS:    rd_row = '0;
         ACCUM: begin
            if (i_reg != IDX_W'(INPUT_DIM - 1)) begin
               rd_row = ROW_W'(i_reg) + ROW_W'(1);
            end
         end
         default: rd_row = ROW_W'(INPUT_DIM);
      endcase
   end

   assign load_bias = (state_reg == BIAS);
   assign accum_en  = (state_reg == ACCUM) && in_latched_reg[i_reg];

   // One weight/bias column per neuron; all columns are read in parallel
   for (genvar gi = 0; gi < OUTPUT_DIM; gi++) begin : g_col
      logic [W_BITLENGTH-1:0] mem [INPUT_DIM+1];
      logic [W_BITLENGTH-1:0] rd_data_reg;

      // Column RAM write port and registered read
      always_ff @(posedge clock) begin
         if (wr_ok && (w_wr_col == COL_W'(gi))) begin
            mem[w_wr_row] <= w_wr_data;
         end
         rd_data_reg <= mem[rd_row];
      end

      assign rd_word[gi] = rd_data_reg;
   end

   // Lane gi serves neuron g*LANES+gi; lanes past the last neuron see zero
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W_BITLENGTH-1:0] lane_value;
      logic                   lane_sample;

      // Select this lane's column for the current group
      always_comb begin
         lane_value = '0;
         for (int c = 0; c < OUTPUT_DIM; c++) begin
            if (c == int'(g_reg) * LANES + gi) begin
               lane_value = rd_word[c];
            end
         end
      end

      rbm_neuron_lane #(
         .BITLENGTH         (BITLENGTH),
         .W_BITLENGTH       (W_BITLENGTH),
         .SIGMOID_BITLENGTH (SIGMOID_BITLENGTH),
         .SAMPLE_MODE       (SAMPLE_MODE)
      ) u_lane (
         .clock      (clock),
         .reset      (reset),
         .load_bias  (load_bias),
         .accum_en   (accum_en),
         .value      (lane_value),
         .rand_val   (rand_data[gi*SIGMOID_BITLENGTH +: SIGMOID_BITLENGTH]),
         .sample_bit (lane_sample)
      );

      assign lane_bit[gi] = lane_sample;
   end

   // Pass sequencing, handshakes and output register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         g_reg          <= '0;
         i_reg          <= '0;
         in_latched_reg <= '0;
         in_ready_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready_reg) begin
                  in_latched_reg <= InputData;
                  in_ready_reg   <= 1'b0;
                  g_reg          <= '0;
                  i_reg          <= '0;
                  state_reg      <= BIAS;
               end else begin
                  in_ready_reg <= 1'b1;
               end
            end
            BIAS: begin
               i_reg     <= '0;
               state_reg <= ACCUM;
            end
            ACCUM: begin
               if (i_reg == IDX_W'(INPUT_DIM - 1)) begin
                  i_reg     <= '0;
                  state_reg <= SAMPLE;
               end else begin
                  i_reg <= i_reg + IDX_W'(1);
               end
            end
            SAMPLE: begin
               for (int l = 0; l < LANES; l++) begin
                  for (int c = 0; c < OUTPUT_DIM; c++) begin
                     if (c == int'(g_reg) * LANES + l) begin
                        out_data_reg[c] <= lane_bit[l];
                     end
                  end
               end
               if (g_reg == GRP_W'(GROUPS - 1)) begin
                  state_reg <= DONE;
               end else begin
                  g_reg     <= g_reg + GRP_W'(1);
                  state_reg <= BIAS;
               end
            end
            DONE: begin
               if (out_valid_reg && out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  out_valid_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign OutputData = out_data_reg;

endmodule

// File: tb/tb_rbm_layer_par.sv
// Directed bench for rbm_layer_par: three instances run in lockstep
// (16-bit threshold, 8-bit threshold for saturation, 16-bit stochastic).
module tb_rbm_layer_par;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        wr_en_a, wr_en_b, wr_en_c;
   logic [2:0]  w_wr_row;
   logic [1:0]  w_wr_col;
   logic [11:0] w_wr_data;
   logic        in_valid;
   logic [3:0]  InputData;
   logic [15:0] rand_data;
   logic        out_ready;

   logic        in_ready_a, in_ready_b, in_ready_c;
   logic        out_valid_a, out_valid_b, out_valid_c;
   logic [2:0]  out_data_a, out_data_b, out_data_c;

   int checks = 0;
   int errors = 0;

   logic [2:0] exp_a_q[$];
   logic [2:0] exp_b_q[$];
   logic [2:0] exp_c_q[$];

   rbm_layer_par #(
      .BITLENGTH(16), .W_BITLENGTH(12), .SIGMOID_BITLENGTH(8),
      .INPUT_DIM(4), .OUTPUT_DIM(3), .LANES(2), .SAMPLE_MODE(1)
   ) dut_a (
      .clock(clock), .reset(reset), .w_wr_en(wr_en_a), .w_wr_row(w_wr_row),
      .w_wr_col(w_wr_col), .w_wr_data(w_wr_data), .in_valid(in_valid),
      .in_ready(in_ready_a), .InputData(InputData), .rand_data(rand_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .OutputData(out_data_a)
   );

   rbm_layer_par #(
      .BITLENGTH(8), .W_BITLENGTH(8), .SIGMOID_BITLENGTH(8),
      .INPUT_DIM(4), .OUTPUT_DIM(3), .LANES(2), .SAMPLE_MODE(1)
   ) dut_b (
      .clock(clock), .reset(reset), .w_wr_en(wr_en_b), .w_wr_row(w_wr_row),
      .w_wr_col(w_wr_col), .w_wr_data(w_wr_data[7:0]), .in_valid(in_valid),
      .in_ready(in_ready_b), .InputData(InputData), .rand_data(rand_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .OutputData(out_data_b)
   );

   rbm_layer_par #(
      .BITLENGTH(16), .W_BITLENGTH(12), .SIGMOID_BITLENGTH(8),
      .INPUT_DIM(4), .OUTPUT_DIM(3), .LANES(2), .SAMPLE_MODE(0)
   ) dut_c (
      .clock(clock), .reset(reset), .w_wr_en(wr_en_c), .w_wr_row(w_wr_row),
      .w_wr_col(w_wr_col), .w_wr_data(w_wr_data), .in_valid(in_valid),
      .in_ready(in_ready_c), .InputData(InputData), .rand_data(rand_data),
      .out_valid(out_valid_c), .out_ready(out_ready), .OutputData(out_data_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] mask, input int row, input int col, input int data);
      wr_en_a   = mask[0];
      wr_en_b   = mask[1];
      wr_en_c   = mask[2];
      w_wr_row  = 3'(row);
      w_wr_col  = 2'(col);
      w_wr_data = 12'(data);
      step();
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
      wr_en_c = 1'b0;
   endtask

   // Pop the scoreboard for each instance and compare against the live outputs
   task automatic score(input string tag);
      logic [3:0] ea, eb, ec;
      ea = (exp_a_q.size() > 0) ? {1'b0, exp_a_q.pop_front()} : 4'hF;
      eb = (exp_b_q.size() > 0) ? {1'b0, exp_b_q.pop_front()} : 4'hF;
      ec = (exp_c_q.size() > 0) ? {1'b0, exp_c_q.pop_front()} : 4'hF;
      chk($sformatf("%s out_a", tag), {1'b0, out_data_a}, ea);
      chk($sformatf("%s out_b", tag), {1'b0, out_data_b}, eb);
      chk($sformatf("%s out_c", tag), {1'b0, out_data_c}, ec);
   endtask

   task automatic run_pass(input string tag, input logic [3:0] vec, input logic [7:0] rnd,
                           input logic [2:0] ea, input logic [2:0] eb, input logic [2:0] ec,
                           input int hold, input bit poke);
      int   t;
      int   lat;
      logic seen;
      rand_data = {rnd, rnd};
      t = 0;
      while (!in_ready_a && t < 40) begin
         step();
         t++;
      end
      chk($sformatf("%s in_ready_before", tag), 32'(in_ready_a), 32'd1);
      in_valid  = 1'b1;
      InputData = vec;
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
      exp_c_q.push_back(ec);
      if (poke) begin
         // offered together with in_valid: must be ignored
         wr_en_a = 1'b1; w_wr_row = 3'd0; w_wr_col = 2'd0; w_wr_data = 12'h801;
      end
      step();
      in_valid = 1'b0;
      wr_en_a  = 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!out_valid_a && lat < 200) begin
         seen = seen | in_ready_a;
         if (poke && lat == 4) begin
            // mid-pass write: must be ignored
            wr_en_a = 1'b1; w_wr_row = 3'd1; w_wr_col = 2'd0; w_wr_data = 12'h801;
         end else begin
            wr_en_a = 1'b0;
         end
         step();
         lat++;
      end
      wr_en_a = 1'b0;
      chk($sformatf("%s latency", tag), 32'(lat), 32'd13);
      chk($sformatf("%s in_ready_during", tag), 32'(seen), 32'd0);
      chk($sformatf("%s out_valid_b", tag), 32'(out_valid_b), 32'd1);
      chk($sformatf("%s out_valid_c", tag), 32'(out_valid_c), 32'd1);
      score(tag);
      for (int k = 0; k < hold; k++) begin
         if (k == 2) begin
            in_valid  = 1'b1;
            InputData = 4'b0000;
         end
         step();
         chk($sformatf("%s hold%0d data", tag, k), 32'(out_data_a), 32'(ea));
         chk($sformatf("%s hold%0d in_ready", tag, k), 32'(in_ready_a), 32'd0);
         chk($sformatf("%s hold%0d out_valid", tag, k), 32'(out_valid_a), 32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("%s out_valid_after", tag), 32'(out_valid_a), 32'd0);
      chk($sformatf("%s in_ready_after", tag), 32'(in_ready_a), 32'd1);
      $display("pass %s vec=%b rnd=%0h a=%b b=%b c=%b latency=%0d", tag, vec, rnd,
               out_data_a, out_data_b, out_data_c, lat);
   endtask

   initial begin
      reset     = 1'b1;
      wr_en_a   = 1'b0;
      wr_en_b   = 1'b0;
      wr_en_c   = 1'b0;
      w_wr_row  = '0;
      w_wr_col  = '0;
      w_wr_data = '0;
      in_valid  = 1'b0;
      InputData = '0;
      rand_data = '0;
      out_ready = 1'b0;

      repeat (3) step();
      chk("reset in_ready", 32'(in_ready_a), 32'd0);
      chk("reset out_valid", 32'(out_valid_a), 32'd0);
      chk("reset out_data", 32'(out_data_a), 32'd0);
      reset = 1'b0;
      step();
      chk("post_reset in_ready", 32'(in_ready_a), 32'd1);

      // A: weights +2, bias {-1,5,0}; B: weights +100, bias 120;
      // C: weights 0, bias {2047,2047,-2048}
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            wr(3'b001, r, c, 2);
            wr(3'b010, r, c, 100);
            wr(3'b100, r, c, 0);
         end
      end
      wr(3'b001, 4, 0, -1);
      wr(3'b001, 4, 1, 5);
      wr(3'b001, 4, 2, 0);
      for (int c = 0; c < 3; c++) wr(3'b010, 4, c, 120);
      wr(3'b100, 4, 0, 2047);
      wr(3'b100, 4, 1, 2047);
      wr(3'b100, 4, 2, -2048);

      run_pass("p1_zero",    4'b0000, 8'h00, 3'b110, 3'b111, 3'b011, 0, 1'b0);
      run_pass("p2_ones",    4'b1111, 8'h00, 3'b111, 3'b111, 3'b011, 0, 1'b1);
      run_pass("p3_satpos",  4'b0111, 8'hFF, 3'b111, 3'b111, 3'b000, 0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) wr(3'b010, r, c, -100);
      end
      for (int c = 0; c < 3; c++) wr(3'b010, 4, c, -120);

      run_pass("p4_satneg_hold", 4'b0111, 8'h00, 3'b111, 3'b000, 3'b011, 10, 1'b0);
      run_pass("p5_back2back",   4'b0000, 8'h00, 3'b110, 3'b000, 3'b011, 0, 1'b0);

      // abort a pass during the second group's accumulation
      in_valid  = 1'b1;
      InputData = 4'b1111;
      step();
      in_valid = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      chk("abort out_valid", 32'(out_valid_a), 32'd0);
      chk("abort out_data_a", 32'(out_data_a), 32'd0);
      chk("abort out_data_b", 32'(out_data_b), 32'd0);
      chk("abort in_ready", 32'(in_ready_a), 32'd0);
      reset = 1'b0;
      step();
      chk("abort in_ready_after", 32'(in_ready_a), 32'd1);
      $display("abort reset applied, in_ready=%b out_data_a=%b", in_ready_a, out_data_a);

      run_pass("p6_after_abort", 4'b0000, 8'h00, 3'b110, 3'b000, 3'b011, 0, 1'b0);

      chk("scoreboard empty", 32'(exp_a_q.size() + exp_b_q.size() + exp_c_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rbm_layer_par.md
Name: rbm_layer_par

Overview:
- Parametrised successor to the single-adder RBM hidden/visible layer.
- Computes OUTPUT_DIM binary stochastic neurons from an INPUT_DIM binary vector, processing LANES neurons in parallel per pass.
- Weights and biases are loaded through a write port rather than file preload; transfers use valid/ready handshakes on input and output.
- A deterministic threshold mode exists for verification and inference.

Parameters:
- BITLENGTH, 16, accumulator width (signed).
- W_BITLENGTH, 12, weight/bias width (signed, sign-extended to BITLENGTH).
- SIGMOID_BITLENGTH, 8, sigmoid output and random-number width.
- INPUT_DIM, 15, input vector length.
- OUTPUT_DIM, 5, output vector length.
- LANES, 2, neurons computed in parallel; 1 <= LANES <= OUTPUT_DIM.
- SAMPLE_MODE, 0, 0 = stochastic (sigmoid > rand), 1 = threshold (acc >= 0).

Ports:
- clock, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- w_wr_en, input, 1, weight/bias write strobe.
- w_wr_row, input, clog2(INPUT_DIM+1), row; rows 0..INPUT_DIM-1 are weights, row INPUT_DIM is bias.
- w_wr_col, input, clog2(OUTPUT_DIM), neuron index.
- w_wr_data, input, W_BITLENGTH, value to write.
- in_valid, input, 1, InputData valid.
- in_ready, output, 1, block can accept a vector.
- InputData, input, INPUT_DIM, binary input vector; bit i = unit i.
- rand_data, input, LANES*SIGMOID_BITLENGTH, per-lane random numbers; lane l occupies bits [l*S +: S].
- out_valid, output, 1, OutputData valid.
- out_ready, input, 1, consumer accepts OutputData.
- OutputData, output, OUTPUT_DIM, sampled binary outputs.

Behaviour:
- Reset: in_ready=0, out_valid=0, OutputData=0, FSM=IDLE, all counters 0. Weight/bias RAM contents are not reset.
- One cycle after reset deasserts: in_ready=1 in IDLE. Reset asserted mid-operation aborts the pass; any partial OutputData is cleared.
- Writes: accepted only in IDLE with in_valid low. In any other state, or if in_valid is high in the same cycle, the write is ignored. A write to row > INPUT_DIM or col >= OUTPUT_DIM is ignored.
- Groups: G = ceil(OUTPUT_DIM/LANES). Group g covers neurons g*LANES+l. Lanes whose neuron index is >= OUTPUT_DIM are masked and write nothing.
- FSM:
  - IDLE: on in_valid & in_ready, latch InputData, deassert in_ready, go to BIAS with g=0.
  - BIAS (1 cycle): acc[l] = sext(bias[n]); i=0; go to ACCUM.
  - ACCUM (INPUT_DIM cycles): acc[l] = sat_add(acc[l], InputData_latched[i] ? sext(W[i][n]) : 0); i++. Exit after i = INPUT_DIM-1.
  - SAMPLE (1 cycle): OutputData[n] = SAMPLE_MODE ? (acc[l] >= 0) : (sigmoid(acc[l]) > rand_data lane l), with rand_data sampled this cycle. If g = G-1, go to DONE; else g++ and go to BIAS.
  - DONE: out_valid=1; hold OutputData stable until out_valid & out_ready; then out_valid=0, in_ready=1, go to IDLE.
- Latency from input handshake to out_valid: G*(INPUT_DIM+2)+1 cycles.
- sat_add: signed BITLENGTH add. Positive overflow clamps to 0x7FFF; negative overflow clamps to 0x8000 (for BITLENGTH=16).
- OutputData bits not yet written in the current pass keep their prior values until overwritten. out_valid is asserted only once all bits are fresh.
- in_ready is low in every state except IDLE; in_valid outside IDLE is ignored.

Decomposition:
- Shared package rbm_pkg holds: sext_w2acc function, sat_add function, clog2 helper, FSM state encoding (IDLE, BIAS, ACCUM, SAMPLE, DONE).
- Sub-module rbm_neuron_lane: one accumulator, the saturating adder, the existing sigmoid instance, and the compare/threshold logic. It is instantiated LANES times.
- The top level holds the FSM, counters, weight/bias RAM and handshake logic.

Test Plan (INPUT_DIM=4, OUTPUT_DIM=3, LANES=2, SAMPLE_MODE=1 unless stated):
1. Load bias={-1,5,0} and all weights=+2; InputData=4'b0000 -> OutputData=3'b110 at cycle 2*(4+2)+1=13 after the handshake; in_ready low throughout.
2. Same weights, InputData=4'b1111 -> acc={7,13,8}, OutputData=3'b111. Write pulses issued during ACCUM leave later results unchanged.
3. BITLENGTH=8, W_BITLENGTH=8: bias=120, weights=+100, all inputs 1 -> acc saturates at 127, not wrapped. Weights=-100, bias=-120 -> saturates at -128, output 0.
4. Hold out_ready=0 for 10 cycles after out_valid -> OutputData stable and in_ready=0; a second in_valid is not accepted until one cycle after the out_ready handshake.
5. SAMPLE_MODE=0, bias=+2047, rand_data all 0x00 -> output 1; rand_data all 0xFF -> output 0.
6. Assert reset in cycle 5 of ACCUM -> next cycle out_valid=0, OutputData=0, in_ready=1 one cycle after reset deasserts; a fresh pass then gives the scenario-1 result.
